// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage.
//  - next-PC operation codes driven by the controller (resolved in EX)
//  - default reset PC and the canonical nop instruction
//  - fetch FSM state encoding
//  - word_align helper used when forming redirect targets
package fetch_stage_pkg;

  // Next-PC operation selects (ex_npc_op)
  localparam logic [1:0] NPC_PC4  = 2'd0;
  localparam logic [1:0] NPC_BR   = 2'd1;
  localparam logic [1:0] NPC_JAL  = 2'd2;
  localparam logic [1:0] NPC_JALR = 2'd3;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_INST         = 32'h0000_0013;

  // Fetch FSM states
  //  StIdle : one quiet cycle after reset
  //  StReq  : request outstanding at pc
  //  StHold : response parked in the hold buffer, waiting for IF/ID to drain
  //  StDrop : a request issued before a redirect is still outstanding; its
  //           response is thrown away
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StHold = 2'd2,
    StDrop = 2'd3
  } fetch_state_e;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_stage_npc_gen.sv
// Next-PC generator (purely combinational).
// Decides whether the instruction in EX redirects fetch and where to.
// Ports:
//  ex_valid    in   EX holds a live instruction
//  ex_npc_op   in   0 pc+4, 1 branch, 2 jal, 3 jalr
//  ex_br_true  in   branch condition result
//  ex_pc       in   PC of the EX instruction
//  ex_imm      in   sign-extended immediate
//  ex_alu_c    in   ALU result (rs1 + imm for jalr)
//  redirect    out  fetch must restart at target
//  target      out  word-aligned redirect address
module fetch_stage_npc_gen
  import fetch_stage_pkg::*;
(
  input  logic        ex_valid,
  input  logic [1:0]  ex_npc_op,
  input  logic        ex_br_true,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_imm,
  input  logic [31:0] ex_alu_c,
  output logic        redirect,
  output logic [31:0] target
);

  logic        take;
  logic [31:0] raw_target;

  always_comb begin
    take       = 1'b0;
    raw_target = ex_pc + ex_imm;
    unique case (ex_npc_op)
      NPC_PC4:  take = 1'b0;
      NPC_BR:   take = ex_br_true;
      NPC_JAL:  take = 1'b1;
      NPC_JALR: begin
        take       = 1'b1;
        raw_target = ex_alu_c & 32'hFFFF_FFFE;
      end
      default:  take = 1'b0;
    endcase
  end

  assign redirect = ex_valid & take;
  // Instruction memory is word addressed; low bits are never meaningful.
  assign target   = word_align(raw_target);

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage.
// Owns the PC, issues one request at a time to a variable-latency instruction
// memory and presents the fetched word to decode through the IF/ID register
// with a valid/ready handshake. Redirects from EX and reset take priority.
// Ports:
//  clk, rst                      clock, synchronous active-high reset
//  imem_req/imem_addr            fetch request and word-aligned address
//  imem_ready/imem_rdata         response strobe (completes request) and data
//  id_valid/id_ready             IF/ID handshake (id_ready=0 is a decode stall)
//  id_pc/id_pc4/id_inst          IF/ID register contents
//  ex_valid, ex_npc_op, ex_br_true, ex_pc, ex_imm, ex_alu_c
//                                EX-stage control-flow resolution inputs
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc4,
  output logic [31:0] id_inst,
  input  logic        ex_valid,
  input  logic [1:0]  ex_npc_op,
  input  logic        ex_br_true,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_imm,
  input  logic [31:0] ex_alu_c
);

  fetch_state_e state;
  logic [31:0]  pc;
  logic [31:0]  hold_pc;
  logic [31:0]  hold_inst;

  logic         redirect;
  logic [31:0]  target;
  logic [31:0]  pc_plus4;
  logic         slot_free;

  fetch_stage_npc_gen u_npc_gen (
    .ex_valid   (ex_valid),
    .ex_npc_op  (ex_npc_op),
    .ex_br_true (ex_br_true),
    .ex_pc      (ex_pc),
    .ex_imm     (ex_imm),
    .ex_alu_c   (ex_alu_c),
    .redirect   (redirect),
    .target     (target)
  );

  assign pc_plus4  = pc + 32'd4;
  assign slot_free = ~id_valid | id_ready;

  // Single FSM block; imem_req/imem_addr are registered alongside the state.
  // imem_addr keeps the in-flight address while in StDrop even though pc has
  // already moved to the redirect target.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= StIdle;
      pc        <= RESET_PC;
      imem_req  <= 1'b0;
      imem_addr <= RESET_PC;
      id_valid  <= 1'b0;
      id_pc     <= 32'h0000_0000;
      id_pc4    <= 32'h0000_0004;
      id_inst   <= NOP_INST;
      hold_pc   <= 32'h0000_0000;
      hold_inst <= NOP_INST;
    end else if (redirect) begin
      pc       <= target;
      id_valid <= 1'b0;
      imem_req <= 1'b1;
      unique case (state)
        StReq: begin
          if (imem_ready) begin
            // Response for the wrong path completes here and is discarded.
            state     <= StReq;
            imem_addr <= target;
          end else begin
            state <= StDrop;
          end
        end
        StDrop: begin
          state <= StDrop;
        end
        StIdle, StHold: begin
          // Leaving StHold implicitly invalidates the hold buffer.
          state     <= StReq;
          imem_addr <= target;
        end
        default: begin
          state     <= StReq;
          imem_addr <= target;
        end
      endcase
    end else begin
      unique case (state)
        StIdle: begin
          state     <= StReq;
          imem_req  <= 1'b1;
          imem_addr <= pc;
        end
        StReq: begin
          if (imem_ready) begin
            pc        <= pc_plus4;
            imem_addr <= pc_plus4;
            if (slot_free) begin
              id_valid <= 1'b1;
              id_pc    <= pc;
              id_pc4   <= pc_plus4;
              id_inst  <= imem_rdata;
            end else begin
              hold_pc   <= pc;
              hold_inst <= imem_rdata;
              imem_req  <= 1'b0;
              state     <= StHold;
            end
          end else if (id_ready) begin
            id_valid <= 1'b0;
          end
        end
        StHold: begin
          if (id_ready) begin
            // pc already points past the buffered word, so it is the link value.
            id_valid <= 1'b1;
            id_pc    <= hold_pc;
            id_pc4   <= pc;
            id_inst  <= hold_inst;
            imem_req <= 1'b1;
            state    <= StReq;
          end
        end
        StDrop: begin
          if (imem_ready) begin
            imem_addr <= pc;
            state     <= StReq;
          end
          if (id_ready) begin
            id_valid <= 1'b0;
          end
        end
        default: begin
          state    <= StIdle;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc;
  logic [31:0] id_pc4;
  logic [31:0] id_inst;
  logic        ex_valid;
  logic [1:0]  ex_npc_op;
  logic        ex_br_true;
  logic [31:0] ex_pc;
  logic [31:0] ex_imm;
  logic [31:0] ex_alu_c;

  int checks = 0;
  int errors = 0;

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rdata (imem_rdata),
    .id_valid   (id_valid),
    .id_ready   (id_ready),
    .id_pc      (id_pc),
    .id_pc4     (id_pc4),
    .id_inst    (id_inst),
    .ex_valid   (ex_valid),
    .ex_npc_op  (ex_npc_op),
    .ex_br_true (ex_br_true),
    .ex_pc      (ex_pc),
    .ex_imm     (ex_imm),
    .ex_alu_c   (ex_alu_c)
  );

  always #5 clk = ~clk;

  // Behavioural model: a fetcher that is either not yet started, waiting on a
  // response it will throw away, holding one parked word, or fetching at pc.
  logic        m_started;
  logic        m_discard;
  logic [31:0] m_stale;
  logic [31:0] m_pc;
  logic        m_buf_v;
  logic [31:0] m_buf_pc;
  logic [31:0] m_buf_inst;
  logic        m_id_valid;
  logic [31:0] m_id_pc;
  logic [31:0] m_id_pc4;
  logic [31:0] m_id_inst;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h5A00_00A5;
  endfunction

  function automatic logic exp_req();
    return m_started && !m_buf_v;
  endfunction

  function automatic logic [31:0] exp_addr();
    return m_discard ? m_stale : m_pc;
  endfunction

  task automatic model_step();
    logic        red;
    logic [31:0] tgt;
    logic        free;
    red = ex_valid && (ex_npc_op == 2'd2 || ex_npc_op == 2'd3 ||
                       (ex_npc_op == 2'd1 && ex_br_true));
    tgt = (ex_npc_op == 2'd3) ? (ex_alu_c & ~32'd1) : (ex_pc + ex_imm);
    tgt = tgt & 32'hFFFF_FFFC;
    if (rst) begin
      m_started = 0; m_discard = 0; m_stale = 0; m_pc = 0; m_buf_v = 0;
      m_id_valid = 0; m_id_pc = 0; m_id_pc4 = 4; m_id_inst = 32'h13;
    end else if (red) begin
      if (!m_started) m_started = 1;
      else if (m_discard) m_discard = 1;
      else if (m_buf_v) m_buf_v = 0;
      else if (!imem_ready) begin
        m_discard = 1;
        m_stale   = m_pc;
      end
      m_pc       = tgt;
      m_id_valid = 0;
    end else begin
      free = !m_id_valid || id_ready;
      if (id_ready) m_id_valid = 0;
      if (!m_started) m_started = 1;
      else if (m_discard) begin
        if (imem_ready) m_discard = 0;
      end else if (m_buf_v) begin
        if (id_ready) begin
          m_id_valid = 1; m_id_pc = m_buf_pc; m_id_pc4 = m_buf_pc + 4;
          m_id_inst = m_buf_inst; m_buf_v = 0;
        end
      end else if (imem_ready) begin
        if (free) begin
          m_id_valid = 1; m_id_pc = m_pc; m_id_pc4 = m_pc + 4; m_id_inst = imem_rdata;
        end else begin
          m_buf_v = 1; m_buf_pc = m_pc; m_buf_inst = imem_rdata;
        end
        m_pc = m_pc + 4;
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic compare();
    chk("imem_req", {31'd0, imem_req}, {31'd0, exp_req()});
    if (exp_req()) chk("imem_addr", imem_addr, exp_addr());
    chk("id_valid", {31'd0, id_valid}, {31'd0, m_id_valid});
    if (m_id_valid) begin
      chk("id_pc", id_pc, m_id_pc);
      chk("id_pc4", id_pc4, m_id_pc4);
      chk("id_inst", id_inst, m_id_inst);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare();
  endtask

  task automatic drive_mem(input int pct);
    imem_ready = exp_req() && ($urandom_range(0, 99) < pct);
    imem_rdata = imem_ready ? mem_word(exp_addr()) : $urandom;
  endtask

  task automatic check_reset();
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_id_valid", {31'd0, id_valid}, 32'd0);
    chk("rst_id_pc", id_pc, 32'h0);
    chk("rst_id_pc4", id_pc4, 32'h4);
    chk("rst_id_inst", id_inst, 32'h0000_0013);
  endtask

  task automatic set_ex(input logic v, input logic [1:0] op, input logic br,
                        input logic [31:0] p, input logic [31:0] im, input logic [31:0] c);
    ex_valid = v; ex_npc_op = op; ex_br_true = br; ex_pc = p; ex_imm = im; ex_alu_c = c;
  endtask

  initial begin
    rst = 1; imem_ready = 0; imem_rdata = 0; id_ready = 1;
    set_ex(0, 2'd0, 0, 0, 0, 0);
    m_started = 0; m_discard = 0; m_stale = 0; m_pc = 0; m_buf_v = 0;
    m_buf_pc = 0; m_buf_inst = 0; m_id_valid = 0; m_id_pc = 0; m_id_pc4 = 4;
    m_id_inst = 32'h13;

    // Sequential fetch with zero-wait memory
    tick(); tick();
    check_reset();
    rst = 0;
    tick();
    chk("t1_req", {31'd0, imem_req}, 32'd1);
    chk("t1_addr0", imem_addr, 32'h0);
    chk("t1_novalid", {31'd0, id_valid}, 32'd0);
    drive_mem(100); tick();
    chk("t1_addr4", imem_addr, 32'h4);
    chk("t1_valid", {31'd0, id_valid}, 32'd1);
    chk("t1_pc0", id_pc, 32'h0);
    chk("t1_pc4", id_pc4, 32'h4);
    chk("t1_inst", id_inst, mem_word(32'h0));
    drive_mem(100); tick();
    chk("t1_addr8", imem_addr, 32'h8);
    chk("t1_pc4b", id_pc, 32'h4);

    // Decode stall while word 0x8 returns
    id_ready = 0;
    for (int i = 0; i < 3; i++) begin
      drive_mem(100); tick();
      chk("t2_hold_pc", id_pc, 32'h4);
    end
    id_ready = 1;
    drive_mem(100); tick();
    chk("t2_pc8", id_pc, 32'h8);
    drive_mem(100); tick();
    chk("t2_pcC", id_pc, 32'hC);
    chk("t2_addr10", imem_addr, 32'h10);

    // Taken branch backwards, then an untaken branch
    set_ex(1, 2'd1, 1, 32'h10, 32'hFFFF_FFF8, 0);
    drive_mem(100); tick();
    chk("t3_addr8", imem_addr, 32'h8);
    chk("t3_flush", {31'd0, id_valid}, 32'd0);
    ex_br_true = 0;
    drive_mem(100); tick();
    chk("t3_nt_valid", {31'd0, id_valid}, 32'd1);
    chk("t3_nt_pc", id_pc, 32'h8);

    // jalr clears bit 0; jal wraps around 2^32
    set_ex(1, 2'd3, 0, 32'h0, 32'h0, 32'h0000_0103);
    drive_mem(100); tick();
    chk("t4_jalr", imem_addr, 32'h100);
    set_ex(1, 2'd2, 0, 32'hFFFF_FFFC, 32'h8, 0);
    drive_mem(100); tick();
    chk("t4_wrap", imem_addr, 32'h4);

    // Redirect while a request is waiting on memory
    set_ex(1, 2'd2, 0, 32'h20, 32'h0, 0);
    drive_mem(100); tick();
    chk("t5_addr20", imem_addr, 32'h20);
    set_ex(1, 2'd2, 0, 32'h40, 32'h0, 0);
    drive_mem(0); tick();
    chk("t5_drop_addr", imem_addr, 32'h20);
    ex_valid = 0;
    drive_mem(0); tick();
    chk("t5_drop_addr2", imem_addr, 32'h20);
    drive_mem(0); tick();
    drive_mem(100); tick();
    chk("t5_addr40", imem_addr, 32'h40);
    chk("t5_dropped", {31'd0, id_valid}, 32'd0);
    drive_mem(100); tick();
    chk("t5_pc40", id_pc, 32'h40);
    chk("t5_inst40", id_inst, mem_word(32'h40));

    // Reset from HOLD and from DROP
    id_ready = 0;
    drive_mem(100); tick();
    drive_mem(100); tick();
    chk("t6_in_hold", {31'd0, imem_req}, 32'd0);
    id_ready = 1; rst = 1; imem_ready = 0;
    tick();
    check_reset();
    rst = 0; imem_ready = 1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    chk("t6_restart", imem_addr, 32'h0);
    chk("t6_late_ign", {31'd0, id_valid}, 32'd0);
    set_ex(1, 2'd2, 0, 32'h80, 32'h0, 0);
    drive_mem(0); tick();
    chk("t6_in_drop", imem_addr, 32'h0);
    ex_valid = 0; rst = 1;
    tick();
    check_reset();
    rst = 0; imem_ready = 1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    chk("t6_restart2", imem_addr, 32'h0);
    chk("t6_late_ign2", {31'd0, id_valid}, 32'd0);
    drive_mem(100); tick();
    chk("t6_first", id_pc, 32'h0);

    // Randomised traffic against the model
    for (int i = 0; i < 4000; i++) begin
      rst      = ($urandom_range(0, 199) == 0);
      id_ready = ($urandom_range(0, 99) < 70);
      ex_valid = ($urandom_range(0, 99) < 12);
      ex_npc_op  = 2'($urandom_range(0, 3));
      ex_br_true = 1'($urandom_range(0, 1));
      ex_pc    = $urandom & 32'hFFFF_FFFC;
      ex_imm   = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 64));
      ex_alu_c = $urandom;
      drive_mem(55);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
